// File: rtl/dehaze_pkg.sv
// dehaze_pkg: shared state encoding, latency and width helpers for the dehaze pipeline
package dehaze_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam int LAT = 3;

    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int pixel_max(input int dw);
        return (1 << dw) - 1;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image line of delay, read-before-write at the column address
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 8,
    parameter int AW    = dehaze_pkg::clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    always_ff @(posedge clk)
        if (we) mem[addr] <= din;
endmodule

// File: rtl/min_window_stream.sv
// min_window_stream: streaming dark channel (channel min, then square-window min) with frame flush
module min_window_stream
    import dehaze_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int R_MAX      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    input  logic                           sof_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic [clog2(R_MAX+1)-1:0]      cfg_radius,
    output logic                           ready_in,
    output logic                           valid_out,
    output logic                           sof_out,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           frame_err
);
    localparam int K   = 2*R_MAX + 1;
    localparam int CW  = clog2(IMG_WIDTH);
    localparam int RWD = clog2(IMG_HEIGHT + R_MAX + 1);
    localparam int RW  = clog2(R_MAX + 1);
    localparam logic [DATA_WIDTH-1:0] PMAX = DATA_WIDTH'(pixel_max(DATA_WIDTH));

    state_t state, state_nx;
    logic [CW-1:0] icol, cur_col, ocol, ocol1;
    logic [RWD-1:0] irow, cur_row, orow;
    logic [RW-1:0] r_act, r_new, eff_r;
    logic accept, start, adv, emit, last_in, last_out;
    logic v1, v2, s1, s2;
    logic [DATA_WIDTH-1:0] taps [K];
    logic [DATA_WIDTH-1:0] lb_out [K-1];
    logic [DATA_WIDTH-1:0] h [K];
    logic [DATA_WIDTH-1:0] vmin, hmin, p2;

    assign ready_in = state != FLUSH;
    assign accept   = valid_in & ready_in;
    assign start    = accept & sof_in;
    assign adv      = start | (accept & state == RUN) | state == FLUSH;
    assign cur_col  = start ? '0 : icol;
    assign cur_row  = start ? '0 : irow;
    assign r_new    = cfg_radius > RW'(R_MAX) ? RW'(R_MAX) : cfg_radius;
    assign eff_r    = start ? r_new : r_act;
    // Step index n emits output n-D, with D = R_MAX*W + R_MAX
    assign emit     = adv & (int'(cur_row) > R_MAX | (int'(cur_row) == R_MAX & int'(cur_col) >= R_MAX));
    assign last_in  = adv & state != FLUSH & int'(cur_row) == IMG_HEIGHT-1 & int'(cur_col) == IMG_WIDTH-1;
    assign last_out = emit & int'(orow) == IMG_HEIGHT-1 & int'(ocol) == IMG_WIDTH-1;

    always_comb begin
        state_nx = state;
        if (last_in) state_nx = FLUSH;
        else if (start) state_nx = RUN;
        else if (state == FLUSH && last_out) state_nx = IDLE;
    end

    genvar g;
    for (g = 0; g < K-1; g++) begin : g_lb
        line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(CW)) u_lb (
            .clk(clk), .we(adv), .addr(cur_col), .din(taps[g]), .dout(lb_out[g])
        );
    end

    // Tap k holds the pixel k lines above the incoming one in the same column
    always_comb begin
        taps[0] = PMAX;
        for (int i = 0; i < CHANNELS; i++)
            taps[0] = data_in[i*DATA_WIDTH +: DATA_WIDTH] < taps[0] ? data_in[i*DATA_WIDTH +: DATA_WIDTH] : taps[0];
        for (int k = 1; k < K; k++)
            taps[k] = lb_out[k-1];
        vmin = PMAX;
        for (int k = 0; k < K; k++)
            if (int'(cur_row) >= k && int'(cur_row) < IMG_HEIGHT + k &&
                (k > R_MAX ? k - R_MAX : R_MAX - k) <= int'(eff_r) && taps[k] < vmin)
                vmin = taps[k];
    end

    // h[j] is the column min j columns left of the newest; the centre sits at j = R_MAX
    always_comb begin
        hmin = PMAX;
        for (int j = 0; j < K; j++)
            if (int'(ocol1) + R_MAX - j >= 0 && int'(ocol1) + R_MAX - j < IMG_WIDTH &&
                (j > R_MAX ? j - R_MAX : R_MAX - j) <= int'(r_act) && h[j] < hmin)
                hmin = h[j];
    end

    always_ff @(posedge clk)
        if (adv) begin
            h[0] <= vmin;
            for (int j = 1; j < K; j++) h[j] <= h[j-1];
        end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            icol      <= '0;
            irow      <= '0;
            ocol      <= '0;
            orow      <= '0;
            ocol1     <= '0;
            r_act     <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            p2        <= '0;
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
            data_out  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_err <= start & state == RUN;
            if (start) r_act <= r_new;
            if (adv) begin
                icol <= int'(cur_col) == IMG_WIDTH-1 ? '0 : cur_col + 1'b1;
                irow <= cur_row + RWD'(int'(cur_col) == IMG_WIDTH-1);
            end
            if (start) begin
                ocol <= '0;
                orow <= '0;
            end else if (emit) begin
                ocol <= int'(ocol) == IMG_WIDTH-1 ? '0 : ocol + 1'b1;
                orow <= int'(ocol) != IMG_WIDTH-1 ? orow : int'(orow) == IMG_HEIGHT-1 ? '0 : orow + 1'b1;
            end
            v1        <= emit;
            s1        <= emit & ocol == '0 & orow == '0;
            ocol1     <= ocol;
            v2        <= v1;
            s2        <= s1;
            p2        <= hmin;
            valid_out <= v2;
            sof_out   <= s2;
            data_out  <= v2 ? p2 : '0;
        end
    end
endmodule

// File: tb/tb_min_window_stream.sv
// tb_min_window_stream: randomized frames checked against a direct window-min reference model
module tb_min_window_stream;
    localparam int W = 8, H = 6, N = W*H, RM = 2, D = RM*W + RM, LAT = 3;

    logic clk = 0, rst_n = 0, valid_in = 0, sof_in = 0;
    logic [23:0] data_in = '0;
    logic [1:0] cfg_radius = '0;
    logic ready_in, valid_out, sof_out, frame_err;
    logic [7:0] data_out;

    int checks = 0, errors = 0, cyc = 0, ferr = 0;
    logic [23:0] frame [N];
    int expv [N];
    int acc_t [N];
    int out_d [$];
    int out_s [$];
    int out_t [$];

    min_window_stream #(.DATA_WIDTH(8), .CHANNELS(3), .IMG_WIDTH(W), .IMG_HEIGHT(H), .R_MAX(RM)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in), .data_in(data_in),
        .cfg_radius(cfg_radius), .ready_in(ready_in), .valid_out(valid_out), .sof_out(sof_out),
        .data_out(data_out), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n) begin
            if (valid_out) begin
                out_d.push_back(int'(data_out));
                out_s.push_back(int'(sof_out));
                out_t.push_back(cyc);
            end
            if (frame_err) ferr++;
        end

    function automatic int chm(input logic [23:0] p);
        int m = 255;
        for (int c = 0; c < 3; c++)
            if (int'(p[c*8 +: 8]) < m) m = int'(p[c*8 +: 8]);
        return m;
    endfunction

    // Direct definition: min of channel mins over the in-image part of the window
    function automatic void build_exp(input int r);
        int rr = r > RM ? RM : r;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                int m = 255;
                for (int dy = -rr; dy <= rr; dy++)
                    for (int dx = -rr; dx <= rr; dx++)
                        if (y+dy >= 0 && y+dy < H && x+dx >= 0 && x+dx < W && chm(frame[(y+dy)*W + x+dx]) < m)
                            m = chm(frame[(y+dy)*W + x+dx]);
                expv[y*W + x] = m;
            end
    endfunction

    task automatic clear_out();
        out_d.delete();
        out_s.delete();
        out_t.delete();
        ferr = 0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < N; i++) frame[i] = 24'($urandom);
    endtask

    task automatic drive_frame(input int r, input int gap, input int npix);
        cfg_radius = 2'(r);
        for (int i = 0; i < npix; i++) begin
            while (int'($urandom_range(99)) < gap) begin
                valid_in = 0;
                @(posedge clk); #1;
            end
            valid_in = 1;
            sof_in = (i == 0);
            data_in = frame[i];
            @(posedge clk); #1;
            acc_t[i] = cyc;
        end
        valid_in = 0;
        sof_in = 0;
    endtask

    task automatic wait_out(input int n);
        int b = 0;
        while (out_d.size() < n && b < 600) begin
            @(posedge clk);
            b++;
        end
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        checks += 5;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %b expected 0", valid_out); end
        if (sof_out !== 1'b0) begin errors++; $display("FAIL reset sof_out: got %b expected 0", sof_out); end
        if (data_out !== 8'd0) begin errors++; $display("FAIL reset data_out: got %0d expected 0", data_out); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %b expected 0", frame_err); end
        if (ready_in !== 1'b1) begin errors++; $display("FAIL reset ready_in: got %b expected 1", ready_in); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_bright_dot();
        int n50 = 0;
        for (int i = 0; i < N; i++) frame[i] = {8'd200, 8'd200, 8'd200};
        frame[2*W + 3] = {8'd70, 8'd90, 8'd50};
        clear_out();
        build_exp(1);
        drive_frame(1, 0, N);
        wait_out(N);
        checks++;
        if (out_d.size() !== N) begin errors++; $display("FAIL dot count: got %0d expected %0d", out_d.size(), N); end
        for (int m = 0; m < out_d.size() && m < N; m++) begin
            checks += 2;
            if (out_d[m] !== expv[m]) begin errors++; $display("FAIL dot data[%0d]: got %0d expected %0d", m, out_d[m], expv[m]); end
            if (out_s[m] !== int'(m == 0)) begin errors++; $display("FAIL dot sof[%0d]: got %0d expected %0d", m, out_s[m], m == 0); end
            if (out_d[m] == 50) n50++;
        end
        checks++;
        if (n50 !== 9) begin errors++; $display("FAIL dot count_50: got %0d expected 9", n50); end
        // Trigger cycle is the accept cycle; valid_out is seen LAT cycles later, i.e. LAT-1 edges after the accept edge
        for (int m = 0; m < N - D && m < out_t.size(); m++) begin
            checks++;
            if (out_t[m] - acc_t[m+D] !== LAT - 1) begin
                errors++;
                $display("FAIL dot latency[%0d]: got %0d expected %0d", m, out_t[m] - acc_t[m+D], LAT - 1);
            end
        end
    endtask

    task automatic test_flush();
        int cnt = 0;
        rand_frame();
        clear_out();
        build_exp(1);
        drive_frame(1, 0, N);
        while (ready_in === 1'b0 && cnt < 100) begin
            valid_in = (cnt == 5);
            sof_in = (cnt == 5);
            data_in = '0;
            @(posedge clk); #1;
            cnt++;
        end
        valid_in = 0;
        sof_in = 0;
        checks++;
        if (cnt !== D) begin errors++; $display("FAIL flush ready_low_cycles: got %0d expected %0d", cnt, D); end
        wait_out(N);
        checks += 3;
        if (out_d.size() !== N) begin errors++; $display("FAIL flush count: got %0d expected %0d", out_d.size(), N); end
        if (ferr !== 0) begin errors++; $display("FAIL flush frame_err: got %0d expected 0", ferr); end
        if (ready_in !== 1'b1) begin errors++; $display("FAIL flush idle_ready: got %b expected 1", ready_in); end
        if (out_t.size() == N) begin
            checks++;
            if (out_t[N-1] - out_t[N-D] !== D - 1) begin
                errors++;
                $display("FAIL flush back_to_back: got %0d expected %0d", out_t[N-1] - out_t[N-D], D - 1);
            end
        end
        for (int m = 0; m < out_d.size() && m < N; m++) begin
            checks++;
            if (out_d[m] !== expv[m]) begin errors++; $display("FAIL flush data[%0d]: got %0d expected %0d", m, out_d[m], expv[m]); end
        end
    endtask

    task automatic test_border();
        for (int r = 1; r >= 0; r--) begin
            int nz = 0;
            for (int i = 0; i < N; i++) frame[i] = 24'hFFFFFF;
            frame[0] = '0;
            clear_out();
            build_exp(r);
            drive_frame(r, 0, N);
            wait_out(N);
            checks++;
            if (out_d.size() !== N) begin errors++; $display("FAIL border r%0d count: got %0d expected %0d", r, out_d.size(), N); end
            for (int m = 0; m < out_d.size() && m < N; m++) begin
                checks++;
                if (out_d[m] !== expv[m]) begin errors++; $display("FAIL border r%0d data[%0d]: got %0d expected %0d", r, m, out_d[m], expv[m]); end
                if (out_d[m] == 0) nz++;
            end
            checks++;
            if (nz !== (r == 1 ? 4 : 1)) begin errors++; $display("FAIL border r%0d zeros: got %0d expected %0d", r, nz, r == 1 ? 4 : 1); end
        end
    endtask

    task automatic test_channel_min();
        for (int i = 0; i < N; i++) frame[i] = {8'd30, 8'd5, 8'd10};
        clear_out();
        drive_frame(1, 0, N);
        wait_out(N);
        checks++;
        if (out_d.size() !== N) begin errors++; $display("FAIL chmin count: got %0d expected %0d", out_d.size(), N); end
        for (int m = 0; m < out_d.size() && m < N; m++) begin
            checks++;
            if (out_d[m] !== 5) begin errors++; $display("FAIL chmin data[%0d]: got %0d expected 5", m, out_d[m]); end
        end
    endtask

    task automatic test_gapped();
        for (int t = 0; t < 2; t++) begin
            int r = t == 0 ? 1 : 3;
            rand_frame();
            clear_out();
            build_exp(r);
            drive_frame(r, t == 0 ? 40 : 20, N);
            wait_out(N);
            checks += 2;
            if (out_d.size() !== N) begin errors++; $display("FAIL gapped r%0d count: got %0d expected %0d", r, out_d.size(), N); end
            if (ferr !== 0) begin errors++; $display("FAIL gapped r%0d frame_err: got %0d expected 0", r, ferr); end
            for (int m = 0; m < out_d.size() && m < N; m++) begin
                checks++;
                if (out_d[m] !== expv[m]) begin errors++; $display("FAIL gapped r%0d data[%0d]: got %0d expected %0d", r, m, out_d[m], expv[m]); end
            end
        end
    endtask

    task automatic test_abort();
        int ea0, ea1;
        rand_frame();
        build_exp(1);
        ea0 = expv[0];
        ea1 = expv[1];
        clear_out();
        drive_frame(1, 0, 20);
        rand_frame();
        build_exp(1);
        drive_frame(1, 0, N);
        wait_out(N + 2);
        checks += 4;
        if (out_d.size() !== N + 2) begin errors++; $display("FAIL abort count: got %0d expected %0d", out_d.size(), N + 2); end
        if (ferr !== 1) begin errors++; $display("FAIL abort frame_err_pulses: got %0d expected 1", ferr); end
        if (out_d.size() > 1 && (out_d[0] !== ea0 || out_d[1] !== ea1)) begin
            errors++;
            $display("FAIL abort old_outputs: got %0d,%0d expected %0d,%0d", out_d[0], out_d[1], ea0, ea1);
        end
        if (out_d.size() < 2) begin errors++; $display("FAIL abort old_outputs: got %0d outputs expected at least 2", out_d.size()); end
        for (int m = 0; m < out_d.size(); m++) begin
            checks++;
            if (out_s[m] !== int'(m == 0 || m == 2)) begin errors++; $display("FAIL abort sof[%0d]: got %0d expected %0d", m, out_s[m], m == 0 || m == 2); end
        end
        for (int m = 0; m + 2 < out_d.size() && m < N; m++) begin
            checks++;
            if (out_d[m+2] !== expv[m]) begin errors++; $display("FAIL abort data[%0d]: got %0d expected %0d", m, out_d[m+2], expv[m]); end
        end
    endtask

    task automatic test_async_reset();
        rand_frame();
        clear_out();
        drive_frame(1, 0, N);
        repeat (4) @(posedge clk);
        #3 rst_n = 0;
        #1;
        checks += 4;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL areset valid_out: got %b expected 0", valid_out); end
        if (sof_out !== 1'b0) begin errors++; $display("FAIL areset sof_out: got %b expected 0", sof_out); end
        if (data_out !== 8'd0) begin errors++; $display("FAIL areset data_out: got %0d expected 0", data_out); end
        if (ready_in !== 1'b1) begin errors++; $display("FAIL areset ready_in: got %b expected 1", ready_in); end
        @(negedge clk);
        rst_n = 1;
        rand_frame();
        clear_out();
        build_exp(1);
        drive_frame(1, 0, N);
        wait_out(N);
        checks += 2;
        if (out_d.size() !== N) begin errors++; $display("FAIL areset count: got %0d expected %0d", out_d.size(), N); end
        if (ferr !== 0) begin errors++; $display("FAIL areset frame_err: got %0d expected 0", ferr); end
        for (int m = 0; m < out_d.size() && m < N; m++) begin
            checks++;
            if (out_d[m] !== expv[m]) begin errors++; $display("FAIL areset data[%0d]: got %0d expected %0d", m, out_d[m], expv[m]); end
        end
    endtask

    initial begin
        test_reset();
        test_bright_dot();
        test_flush();
        test_border();
        test_channel_min();
        test_gapped();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
